// File: rtl/sys_output_collector_pkg.sv
// Shared configuration for the GEMM output collector.
// Array geometry, datapath widths, FSM state encoding and the default accumulator row type.
package sys_output_collector_pkg;

  localparam int SUPER_SYS_COLS = 16;
  localparam int SUPER_SYS_ROWS = 16;
  localparam int P_BITWIDTH     = 24;
  localparam int ACC_BITWIDTH   = 32;

  // Fixed encodings so older RTL/scripts that probe the state bits keep working.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    COLLECT = ST_COLLECT,
    DRAIN   = ST_DRAIN
  } collector_state_e;

  typedef logic [SUPER_SYS_COLS-1:0][ACC_BITWIDTH-1:0] acc_row_t;

endpackage

// File: rtl/sys_output_collector_skew.sv
// skew_delay_line: plain shift register used to remove the column skew.
// Ports: clk, rst (async, active-high), din[WIDTH], dout[WIDTH] = din delayed DEPTH cycles.
// DEPTH=0 degenerates to a wire.
module skew_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end
      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sys_output_collector.sv
// sys_output_collector: deskews the array's column outputs, accumulates rows over K-tiles
// in a flop row buffer and drains finished rows over valid/ready.
// Ports: clk, rst (async, active-high); of_data/valid/accum_start/first_tile/last_tile from
// the array; out_valid/out_ready/out_data/out_row to writeback; busy; err (sticky).
//
// state   | meaning
// IDLE    | waiting for a deskewed accum_start
// COLLECT | writing/accumulating aligned rows into the buffer
// DRAIN   | presenting buffered rows to writeback, one per handshake
module sys_output_collector
  import sys_output_collector_pkg::*;
#(
  parameter int COLS  = SUPER_SYS_COLS,
  parameter int ROWS  = SUPER_SYS_ROWS,
  parameter int P_W   = P_BITWIDTH,
  parameter int ACC_W = ACC_BITWIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [COLS*P_W-1:0]     of_data,
  input  logic                    valid,
  input  logic                    accum_start,
  input  logic                    first_tile,
  input  logic                    last_tile,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*ACC_W-1:0]   out_data,
  output logic [$clog2(ROWS)-1:0] out_row,
  output logic                    busy,
  output logic                    err
);

  localparam int AW    = $clog2(ROWS);
  localparam int PW    = AW + 1;
  localparam int CNT_W = (COLS > 2) ? $clog2(COLS) : 1;

  typedef logic [COLS-1:0][ACC_W-1:0] row_t;

  logic [P_W-1:0] dcol [COLS];
  logic [3:0]     dctl;
  logic           dvalid, dstart, dfirst, dlast;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    skew_delay_line #(.WIDTH(P_W), .DEPTH(COLS-1-c)) u_col (
      .clk (clk),
      .rst (rst),
      .din (of_data[c*P_W +: P_W]),
      .dout(dcol[c])
    );
  end

  // first/last travel with accum_start so they are sampled when the tile arrives aligned.
  skew_delay_line #(.WIDTH(4), .DEPTH(COLS-1)) u_ctl (
    .clk (clk),
    .rst (rst),
    .din ({last_tile, first_tile, accum_start, valid}),
    .dout(dctl)
  );
  assign {dlast, dfirst, dstart, dvalid} = dctl;

  // Pipe occupancy: reloaded on any control input, empty once it counts down to zero.
  logic [CNT_W-1:0] pipe_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       pipe_cnt <= '0;
    else if (valid || accum_start) pipe_cnt <= CNT_W'(COLS-1);
    else if (pipe_cnt != '0)       pipe_cnt <= pipe_cnt - CNT_W'(1);
  end

  collector_state_e state;
  logic [PW-1:0]    row_ptr, n_rows, rd_ptr;
  logic             first_q, last_q, dvalid_q;
  row_t             row_buf [ROWS];
  row_t             wr_row;
  logic [AW-1:0]    wr_idx;

  assign busy = (state != IDLE) || (pipe_cnt != '0);

  logic tile_end, hs, more, can_load, wr_en;
  assign tile_end = dvalid_q && !dvalid;
  assign hs       = out_valid && out_ready;
  assign more     = rd_ptr < n_rows;
  assign can_load = !out_valid || hs;
  assign wr_en    = (state == COLLECT) && dvalid && (row_ptr != PW'(ROWS));
  assign wr_idx   = row_ptr[AW-1:0];

  always_comb begin
    wr_row = '0;
    for (int c = 0; c < COLS; c++) begin
      if (first_q) wr_row[c] = ACC_W'($signed(dcol[c]));
      else         wr_row[c] = row_buf[wr_idx][c] + ACC_W'($signed(dcol[c]));
    end
  end

  // Buffer contents are don't-care after reset; the first tile always overwrites.
  always_ff @(posedge clk) begin
    if (wr_en) row_buf[wr_idx] <= wr_row;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row_ptr   <= '0;
      n_rows    <= '0;
      rd_ptr    <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      dvalid_q  <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
    end else begin
      dvalid_q <= dvalid;
      unique case (state)
        IDLE: begin
          if (dstart) begin
            state   <= COLLECT;
            first_q <= dfirst;
            last_q  <= dlast;
            row_ptr <= '0;
          end else if (dvalid) begin
            err <= 1'b1;
          end
        end
        COLLECT: begin
          if (dvalid) begin
            if (row_ptr == PW'(ROWS)) err <= 1'b1;
            else                      row_ptr <= row_ptr + PW'(1);
          end
          if (tile_end) begin
            if (last_q) begin
              state  <= DRAIN;
              n_rows <= row_ptr;
              rd_ptr <= '0;
              if (dstart) err <= 1'b1;
            end else if (dstart) begin
              // back-to-back tile: restart without passing through IDLE
              first_q <= dfirst;
              last_q  <= dlast;
              row_ptr <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (dstart) begin
            err <= 1'b1;
          end
        end
        DRAIN: begin
          // a new tile is only accepted together with the final handshake
          if (dvalid || (dstart && !(can_load && !more))) err <= 1'b1;
          if (can_load) begin
            if (more) begin
              out_valid <= 1'b1;
              out_data  <= row_buf[rd_ptr[AW-1:0]];
              out_row   <= rd_ptr[AW-1:0];
              rd_ptr    <= rd_ptr + PW'(1);
            end else begin
              out_valid <= 1'b0;
              if (dstart) begin
                state   <= COLLECT;
                first_q <= dfirst;
                last_q  <= dlast;
                row_ptr <= '0;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_output_collector.sv
module tb_sys_output_collector;

  localparam int COLS  = 16;
  localparam int ROWS  = 16;
  localparam int P_W   = 24;
  localparam int ACC_W = 32;
  localparam int DW    = COLS*ACC_W;
  localparam int CW    = 544;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [COLS*P_W-1:0]   of_data;
  logic                  valid, accum_start, first_tile, last_tile;
  logic                  out_valid, out_ready, busy, err;
  logic [DW-1:0]         out_data;
  logic [3:0]            out_row;

  always #5 clk = ~clk;

  sys_output_collector dut (
    .clk        (clk),
    .rst        (rst),
    .of_data    (of_data),
    .valid      (valid),
    .accum_start(accum_start),
    .first_tile (first_tile),
    .last_tile  (last_tile),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .busy       (busy),
    .err        (err)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [3:0] row; logic [DW-1:0] data; } out_rec_t;
  out_rec_t       exp_q[$];
  int             acc_m [ROWS][COLS];
  int             defined_rows = 0;
  bit             err_m = 1'b0;
  logic [P_W-1:0] tile_rows [32][COLS];

  task automatic fill_rows(input int pat, input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < COLS; c++)
        case (pat)
          0:       tile_rows[r][c] = P_W'(r*16 + c);
          1:       tile_rows[r][c] = P_W'(1);
          2:       tile_rows[r][c] = '1;
          default: tile_rows[r][c] = P_W'($urandom);
        endcase
  endtask

  task automatic model_tile(input bit f, input bit l, input int n);
    int nw;
    out_rec_t rec;
    nw = (n > ROWS) ? ROWS : n;
    for (int r = 0; r < nw; r++)
      for (int c = 0; c < COLS; c++) begin
        int v;
        v = int'($signed(tile_rows[r][c]));
        acc_m[r][c] = f ? v : acc_m[r][c] + v;
      end
    if (n > ROWS) err_m = 1'b1;
    if (f && nw > defined_rows) defined_rows = nw;
    if (l)
      for (int r = 0; r < nw; r++) begin
        rec.row = 4'(r);
        for (int c = 0; c < COLS; c++) rec.data[c*ACC_W +: ACC_W] = acc_m[r][c];
        exp_q.push_back(rec);
      end
  endtask

  // ---------------- writeback side ----------------
  int ready_mode = 0;
  int phase;
  always @(posedge clk) begin
    #1;
    phase++;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (phase % 4 == 0) || (phase % 4 == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  bit ov_prev;
  int rise_cyc;
  int n_drained;
  always @(negedge clk) begin
    if (rst) ov_prev = 1'b0;
    else begin
      if (out_valid && !ov_prev) rise_cyc = cyc;
      ov_prev = out_valid;
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_row", CW'(out_valid), CW'(0));
        else begin
          check("out_data", CW'(out_data), CW'(exp_q[0].data));
          check("out_row", CW'(out_row), CW'(exp_q[0].row));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_drained++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst = 1'b1;
    valid = 1'b0;
    accum_start = 1'b0;
    #1;
    check("reset_outputs", CW'({out_valid, out_row, busy, err, out_data}), CW'(0));
    exp_q.delete();
    defined_rows = 0;
    err_m = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_tile(input bit f, input bit l, input int n, input int abort_k,
                            output int t_last);
    t_last = 0;
    for (int k = 0; k <= n + COLS - 1; k++) begin
      @(negedge clk);
      if (k == abort_k) begin
        do_reset();
        return;
      end
      accum_start = (k == 0);
      first_tile  = (k == 0) ? f : 1'($urandom);
      last_tile   = (k == 0) ? l : 1'($urandom);
      valid       = (k >= 1) && (k <= n);
      if (k == n) t_last = cyc + 1;
      for (int c = 0; c < COLS; c++) begin
        int r;
        r = k - 1 - c;
        of_data[c*P_W +: P_W] = (r >= 0 && r < n) ? tile_rows[r][c] : P_W'($urandom);
      end
    end
    @(negedge clk);
    accum_start = 1'b0;
    valid = 1'b0;
  endtask

  task automatic run_tile(input bit f, input bit l, input int n, input int pat, input int rm,
                          output int drained);
    int t_last, n0, w;
    fill_rows(pat, n);
    model_tile(f, l, n);
    ready_mode = rm;
    n0 = n_drained;
    drive_tile(f, l, n, -1, t_last);
    w = 0;
    while (busy && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("idle_timeout", CW'(busy), CW'(0));
    check("out_valid_idle", CW'(out_valid), CW'(0));
    check("rows_left", CW'(exp_q.size()), CW'(0));
    check("err", CW'(err), CW'(err_m));
    drained = n_drained - n0;
    check("drained_count", CW'(drained), CW'(l ? ((n > ROWS) ? ROWS : n) : 0));
    if (l) check("drain_latency", CW'(rise_cyc), CW'(t_last + COLS + 1));
  endtask

  typedef struct {
    bit first; bit last; int nrows; int pat; int rmode;
    bit exp_err; int exp_rows;
  } tile_vec_t;
  tile_vec_t tv[6];

  initial begin
    int drained, t_dummy;
    tv[0] = '{1, 1, 4,  0, 0, 1'b0, 4};
    tv[1] = '{1, 0, 3,  1, 0, 1'b0, 0};
    tv[2] = '{0, 1, 3,  1, 0, 1'b0, 3};
    tv[3] = '{1, 0, 2,  2, 0, 1'b0, 0};
    tv[4] = '{0, 1, 2,  2, 1, 1'b0, 2};
    tv[5] = '{1, 1, 17, 3, 0, 1'b1, 16};

    valid = 1'b0; accum_start = 1'b0; first_tile = 1'b0; last_tile = 1'b0;
    of_data = '0;
    do_reset();

    for (int i = 0; i < 6; i++) begin
      run_tile(tv[i].first, tv[i].last, tv[i].nrows, tv[i].pat, tv[i].rmode, drained);
      check("table_rows", CW'(drained), CW'(tv[i].exp_rows));
      check("table_err", CW'(err), CW'(tv[i].exp_err));
    end

    // reset in the middle of COLLECT, then a fresh tile must not see the old data
    fill_rows(3, 10);
    drive_tile(1'b1, 1'b1, 10, 20, t_dummy);
    check("err_after_reset", CW'(err), CW'(0));
    run_tile(1'b1, 1'b1, 3, 3, 2, drained);

    for (int i = 0; i < 20; i++) begin
      bit f, l;
      int n;
      f = (defined_rows == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      n = f ? $urandom_range(1, ROWS) : $urandom_range(1, defined_rows);
      run_tile(f, l, n, 3, $urandom_range(0, 2), drained);
    end

    // valid without accum_start while idle is dropped and flagged
    @(negedge clk);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (COLS + 4) @(negedge clk);
    err_m = 1'b1;
    check("idle_valid_err", CW'(err), CW'(err_m));
    check("idle_valid_busy", CW'(busy), CW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
